alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Decode-and-issue stage for the MIPS datapath. It decodes each instruction into the 5-bit ALU control code and the two 32-bit ALU operands the ALU expects, and registers them in an ID/EX pipeline register with stall, flush and valid semantics. It sits between the register file and the ALU, and is the sole producer of the ALU's control and operand inputs.

## Interface
- No parameters. Widths are fixed at 32-bit data, 5-bit control and 5-bit register numbers.
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-low reset.
- InValid  in  1  Instruction/RsData/RtData hold a real instruction this cycle.
- Instruction  in  32  instruction word.
- RsData  in  32  register-file read of rs.
- RtData  in  32  register-file read of rt.
- Stall  in  1  hold the pipeline register.
- Flush  in  1  replace the pipeline register contents with a bubble.
- ExValid  out  1  pipeline register holds a valid instruction.
- ALUControl  out  5  ALU operation code.
- ALUOpA  out  32  ALU operand A.
- ALUOpB  out  32  ALU operand B.
- ExWriteReg  out  5  destination register number.
- ExRegWrite  out  1  the instruction writes ExWriteReg.
- IllegalInstr  out  1  the held instruction has an undecodable opcode/funct.
- IssueCount  out  32  number of valid instructions issued since reset.

## Operation
- ALU codes:
  - 1 add, 2 sub, 3 mul, 4 sll, 5 srl, 6 and, 7 or, 8 xor.
  - 11 A>=B, 12 A==B, 13 nor, 14 slt, 15 A!=B, 16 A>B, 17 A<=B, 18 A<B.
  - 0 no-op, which makes the ALU output a result of 0.
- The ALU takes the shift amount from A[10:6]. For every shift, ALUOpA = {21'b0, shamt, 6'b0}.
- Immediates: sext = sign-extended Instruction[15:0]; zext = zero-extended Instruction[15:0].
- R-type (opcode 0), A=RsData, B=RtData, ExWriteReg=rd, ExRegWrite=1:
  - funct 0x20/0x21 → 1; 0x22 → 2.
  - 0x24 → 6; 0x25 → 7; 0x26 → 8; 0x27 → 13; 0x2A → 14.
  - funct 0x00 → 4 and 0x02 → 5, with A = shamt form and B = RtData.
  - funct 0x08 (jr) → 0, ExRegWrite=0.
- mul (opcode 0x1C, funct 0x02) → 3, A=RsData, B=RtData, ExWriteReg=rd.
- I-type ALU, A=RsData, ExWriteReg=rt, ExRegWrite=1:
  - 0x08/0x09 → 1, B=sext.
  - 0x0A → 14, B=sext.
  - 0x0C → 6, 0x0D → 7, 0x0E → 8, each with B=zext.
- lui (0x0F) → 4, A=32'h0000_0400 (shamt 16), B=zext, ExWriteReg=rt.
- Loads 0x20/0x21/0x23 → 1, A=RsData, B=sext, ExWriteReg=rt, ExRegWrite=1.
- Stores 0x28/0x29/0x2B → 1, A=RsData, B=sext, ExRegWrite=0.
- Branches (ExRegWrite=0):
  - beq 0x04 → 12 and bne 0x05 → 15, with A=RsData, B=RtData.
  - bgtz 0x07 → 16 and blez 0x06 → 17, with A=RsData, B=0.
  - opcode 0x01: rt=1 (bgez) → 11; rt=0 (bltz) → 18; A=RsData, B=0.
- j 0x02 → 0, ExRegWrite=0. jal 0x03 → 0, ExWriteReg=31, ExRegWrite=1.
- Any other opcode, funct, or opcode-0x01 rt value is illegal. An illegal instruction issues as ALUControl=0, A=B=0, ExRegWrite=0, IllegalInstr=1, ExValid=1.
- Register update, evaluated at each rising edge in priority order:
  1. Reset=0: all outputs 0, including IssueCount.
  2. Flush=1: bubble. All outputs except IssueCount go to 0. Flush beats Stall.
  3. Stall=1: hold all outputs, including IssueCount.
  4. Otherwise, load the decode of the current inputs. If InValid=0, load a bubble.
- IssueCount increments by 1 only on a case-4 load with InValid=1. Illegal instructions count. It wraps 0xFFFF_FFFF → 0.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on outputs after edge N.
- All outputs are registered; there is no combinational input-to-output path.
- Throughput is one instruction per cycle while Stall=0.
- Reset is synchronous: asserting it mid-stream discards the held instruction at the next edge. Asynchronous assertion has no effect until that edge.
- Stall held for k cycles: outputs are constant for k cycles, and the next unstalled edge loads the inputs present at that edge.

## Test plan
- Reset=0 for one edge with InValid=1 and any instruction → every output 0, IssueCount=0.
- add, Instruction=0x00221820, RsData=5, RtData=7 → ALUControl=1, ALUOpA=5, ALUOpB=7, ExWriteReg=3, ExRegWrite=1, IssueCount=1.
- Shifts and lui:
  - 0x00011100 with RtData=3 → ALUControl=4, ALUOpA=0x100, ALUOpB=3, ExWriteReg=2.
  - 0x3C051234 → ALUControl=4, ALUOpA=0x400, ALUOpB=0x1234, ExWriteReg=5.
- Immediates and branches:
  - 0x2004FFFF → ALUControl=1, ALUOpB=0xFFFFFFFF.
  - 0x3084FFFF → ALUControl=6, ALUOpB=0x0000FFFF.
  - 0x04210003 (bgez) → ALUControl=11, ALUOpB=0, ExRegWrite=0.
- Stall, flush and illegal:
  - Stall=1 for 3 cycles while the inputs change → outputs and IssueCount unchanged.
  - Stall=1 and Flush=1 together → ExValid=0, ALUControl=0.
  - Opcode 0x3F → IllegalInstr=1, ALUControl=0, IssueCount incremented.
- Bubble and wrap:
  - InValid=0 → ExValid=0, all ALU fields 0, IssueCount unchanged.
  - IssueCount forced to 0xFFFFFFFF, then one valid issue → IssueCount=0.

Source files
------------

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes a MIPS instruction into the ALU control code and the
// two ALU operands, then holds them in an ID/EX pipeline register that
// supports stall, flush and valid/bubble semantics.
module alu_issue_stage (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        InValid,
    input  logic [31:0] Instruction,
    input  logic [31:0] RsData,
    input  logic [31:0] RtData,
    input  logic        Stall,
    input  logic        Flush,
    output logic        ExValid,
    output logic [4:0]  ALUControl,
    output logic [31:0] ALUOpA,
    output logic [31:0] ALUOpB,
    output logic [4:0]  ExWriteReg,
    output logic        ExRegWrite,
    output logic        IllegalInstr,
    output logic [31:0] IssueCount
);

    typedef enum logic [4:0] {
        ALU_NOP = 5'd0,
        ALU_ADD = 5'd1,
        ALU_SUB = 5'd2,
        ALU_MUL = 5'd3,
        ALU_SLL = 5'd4,
        ALU_SRL = 5'd5,
        ALU_AND = 5'd6,
        ALU_OR  = 5'd7,
        ALU_XOR = 5'd8,
        ALU_GE  = 5'd11,
        ALU_EQ  = 5'd12,
        ALU_NOR = 5'd13,
        ALU_SLT = 5'd14,
        ALU_NE  = 5'd15,
        ALU_GT  = 5'd16,
        ALU_LE  = 5'd17,
        ALU_LT  = 5'd18
    } alu_op_e;

    // Everything the EX stage receives for one instruction; all-zero is a bubble.
    typedef struct packed {
        alu_op_e     ctrl;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [4:0]  wreg;
        logic        regwrite;
        logic        illegal;
    } issue_t;

    logic [5:0]  w_opcode;
    logic [5:0]  w_funct;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [31:0] w_shamt_a;
    logic [31:0] w_sext;
    logic [31:0] w_zext;
    logic        w_unused_rs;
    issue_t      w_dec;

    issue_t      r_issue;
    logic        r_valid;
    logic [31:0] r_issue_count;

    assign w_opcode  = Instruction[31:26];
    assign w_rt      = Instruction[20:16];
    assign w_rd      = Instruction[15:11];
    assign w_funct   = Instruction[5:0];
    // The ALU reads the shift amount from A[10:6], so shamt keeps its field position.
    assign w_shamt_a = {21'b0, Instruction[10:6], 6'b0};
    assign w_sext    = {{16{Instruction[15]}}, Instruction[15:0]};
    assign w_zext    = {16'b0, Instruction[15:0]};
    // The rs field only addresses the register file; its data arrives on RsData.
    assign w_unused_rs = ^Instruction[25:21];

    // Decode the current instruction into control, operands and destination.
    always_comb begin
        // NOTE: every field gets a default before the case so no path can infer a latch.
        w_dec = '0;
        case (w_opcode)
            6'h00: begin
                w_dec.op_a     = RsData;
                w_dec.op_b     = RtData;
                w_dec.wreg     = w_rd;
                w_dec.regwrite = 1'b1;
                case (w_funct)
                    6'h20, 6'h21: w_dec.ctrl = ALU_ADD;
                    6'h22:        w_dec.ctrl = ALU_SUB;
                    6'h24:        w_dec.ctrl = ALU_AND;
                    6'h25:        w_dec.ctrl = ALU_OR;
                    6'h26:        w_dec.ctrl = ALU_XOR;
                    6'h27:        w_dec.ctrl = ALU_NOR;
                    6'h2A:        w_dec.ctrl = ALU_SLT;
                    6'h00: begin
                        w_dec.ctrl = ALU_SLL;
                        w_dec.op_a = w_shamt_a;
                    end
                    6'h02: begin
                        w_dec.ctrl = ALU_SRL;
                        w_dec.op_a = w_shamt_a;
                    end
                    6'h08: begin
                        w_dec.ctrl     = ALU_NOP;
                        w_dec.regwrite = 1'b0;
                    end
                    default: begin
                        w_dec         = '0;
                        w_dec.illegal = 1'b1;
                    end
                endcase
            end
            6'h1C: begin
                if (w_funct == 6'h02) begin
                    w_dec.ctrl     = ALU_MUL;
                    w_dec.op_a     = RsData;
                    w_dec.op_b     = RtData;
                    w_dec.wreg     = w_rd;
                    w_dec.regwrite = 1'b1;
                end else begin
                    w_dec.illegal  = 1'b1;
                end
            end
            6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E,
            6'h20, 6'h21, 6'h23: begin
                w_dec.op_a     = RsData;
                w_dec.wreg     = w_rt;
                w_dec.regwrite = 1'b1;
                case (w_opcode)
                    6'h0A: begin w_dec.ctrl = ALU_SLT; w_dec.op_b = w_sext; end
                    6'h0C: begin w_dec.ctrl = ALU_AND; w_dec.op_b = w_zext; end
                    6'h0D: begin w_dec.ctrl = ALU_OR;  w_dec.op_b = w_zext; end
                    6'h0E: begin w_dec.ctrl = ALU_XOR; w_dec.op_b = w_zext; end
                    default: begin w_dec.ctrl = ALU_ADD; w_dec.op_b = w_sext; end
                endcase
            end
            6'h0F: begin
                w_dec.ctrl     = ALU_SLL;
                w_dec.op_a     = 32'h0000_0400;
                w_dec.op_b     = w_zext;
                w_dec.wreg     = w_rt;
                w_dec.regwrite = 1'b1;
            end
            6'h28, 6'h29, 6'h2B: begin
                w_dec.ctrl = ALU_ADD;
                w_dec.op_a = RsData;
                w_dec.op_b = w_sext;
            end
            6'h04: begin w_dec.ctrl = ALU_EQ; w_dec.op_a = RsData; w_dec.op_b = RtData; end
            6'h05: begin w_dec.ctrl = ALU_NE; w_dec.op_a = RsData; w_dec.op_b = RtData; end
            6'h06: begin w_dec.ctrl = ALU_LE; w_dec.op_a = RsData; end
            6'h07: begin w_dec.ctrl = ALU_GT; w_dec.op_a = RsData; end
            6'h01: begin
                w_dec.op_a = RsData;
                if (w_rt == 5'd1) begin
                    w_dec.ctrl = ALU_GE;
                end else if (w_rt == 5'd0) begin
                    w_dec.ctrl = ALU_LT;
                end else begin
                    w_dec.op_a    = '0;
                    w_dec.illegal = 1'b1;
                end
            end
            6'h02: w_dec.ctrl = ALU_NOP;
            6'h03: begin
                w_dec.wreg     = 5'd31;
                w_dec.regwrite = 1'b1;
            end
            default: w_dec.illegal = 1'b1;
        endcase
    end

    // ID/EX register: reset, then flush, then stall, then load or bubble.
    always_ff @(posedge Clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (!Reset) begin
            r_valid       <= 1'b0;
            r_issue       <= '0;
            r_issue_count <= '0;
        end else if (Flush) begin
            r_valid <= 1'b0;
            r_issue <= '0;
        end else if (!Stall) begin
            if (InValid) begin
                r_valid       <= 1'b1;
                r_issue       <= w_dec;
                r_issue_count <= r_issue_count + 32'd1;
            end else begin
                r_valid <= 1'b0;
                r_issue <= '0;
            end
        end
    end

    assign ExValid      = r_valid;
    assign ALUControl   = r_issue.ctrl;
    assign ALUOpA       = r_issue.op_a;
    assign ALUOpB       = r_issue.op_b;
    assign ExWriteReg   = r_issue.wreg;
    assign ExRegWrite   = r_issue.regwrite;
    assign IllegalInstr = r_issue.illegal;
    assign IssueCount   = r_issue_count;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed testbench for alu_issue_stage with hand-computed expected values.
module tb_alu_issue_stage;

    logic        Clk;
    logic        Reset;
    logic        InValid;
    logic [31:0] Instruction;
    logic [31:0] RsData;
    logic [31:0] RtData;
    logic        Stall;
    logic        Flush;
    logic        ExValid;
    logic [4:0]  ALUControl;
    logic [31:0] ALUOpA;
    logic [31:0] ALUOpB;
    logic [4:0]  ExWriteReg;
    logic        ExRegWrite;
    logic        IllegalInstr;
    logic [31:0] IssueCount;

    int checks   = 0;
    int failures = 0;

    alu_issue_stage dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .InValid      (InValid),
        .Instruction  (Instruction),
        .RsData       (RsData),
        .RtData       (RtData),
        .Stall        (Stall),
        .Flush        (Flush),
        .ExValid      (ExValid),
        .ALUControl   (ALUControl),
        .ALUOpA       (ALUOpA),
        .ALUOpB       (ALUOpB),
        .ExWriteReg   (ExWriteReg),
        .ExRegWrite   (ExRegWrite),
        .IllegalInstr (IllegalInstr),
        .IssueCount   (IssueCount)
    );

    // 10-unit clock.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Hard stop in case the run ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and sample 1 unit after it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr,
                         input logic [31:0] rs, input logic [31:0] rt);
        InValid     = v;
        Instruction = instr;
        RsData      = rs;
        RtData      = rt;
    endtask

    task automatic check_all(input string tag, input logic v, input logic [4:0] ctrl,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] wreg, input logic rw,
                             input logic ill, input logic [31:0] cnt);
        check({tag, ".valid"},   {31'b0, ExValid},      {31'b0, v});
        check({tag, ".ctrl"},    {27'b0, ALUControl},   {27'b0, ctrl});
        check({tag, ".opa"},     ALUOpA,                a);
        check({tag, ".opb"},     ALUOpB,                b);
        check({tag, ".wreg"},    {27'b0, ExWriteReg},   {27'b0, wreg});
        check({tag, ".regwr"},   {31'b0, ExRegWrite},   {31'b0, rw});
        check({tag, ".illegal"}, {31'b0, IllegalInstr}, {31'b0, ill});
        check({tag, ".count"},   IssueCount,            cnt);
    endtask

    initial begin
        Reset = 1'b0;
        Stall = 1'b0;
        Flush = 1'b0;
        drive(1'b1, 32'h0022_1820, 32'd5, 32'd7);
        #2;
        tick();
        check_all("reset", 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'd0);

        Reset = 1'b1;
        tick();
        check_all("add", 1'b1, 5'd1, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0, 32'd1);

        drive(1'b1, 32'h0001_1100, 32'hDEAD_BEEF, 32'd3);
        tick();
        check_all("sll", 1'b1, 5'd4, 32'h100, 32'd3, 5'd2, 1'b1, 1'b0, 32'd2);

        drive(1'b1, 32'h3C05_1234, 32'h1111_1111, 32'h2222_2222);
        tick();
        check_all("lui", 1'b1, 5'd4, 32'h400, 32'h1234, 5'd5, 1'b1, 1'b0, 32'd3);

        drive(1'b1, 32'h2004_FFFF, 32'd9, 32'h3333_3333);
        tick();
        check_all("addi", 1'b1, 5'd1, 32'd9, 32'hFFFF_FFFF, 5'd4, 1'b1, 1'b0, 32'd4);

        drive(1'b1, 32'h3084_FFFF, 32'h0F0F_0F0F, 32'h4444_4444);
        tick();
        check_all("andi", 1'b1, 5'd6, 32'h0F0F_0F0F, 32'h0000_FFFF, 5'd4, 1'b1, 1'b0, 32'd5);

        drive(1'b1, 32'h0421_0003, 32'h8000_0000, 32'h5555_5555);
        tick();
        check_all("bgez", 1'b1, 5'd11, 32'h8000_0000, 32'h0, 5'd0, 1'b0, 1'b0, 32'd6);

        drive(1'b1, 32'h1043_0005, 32'd12, 32'd34);
        tick();
        check_all("beq", 1'b1, 5'd12, 32'd12, 32'd34, 5'd0, 1'b0, 1'b0, 32'd7);

        Stall = 1'b1;
        drive(1'b1, 32'h0022_1820, 32'd100, 32'd200);
        tick();
        check_all("stall1", 1'b1, 5'd12, 32'd12, 32'd34, 5'd0, 1'b0, 1'b0, 32'd7);
        drive(1'b1, 32'h3C05_1234, 32'd101, 32'd201);
        tick();
        check_all("stall2", 1'b1, 5'd12, 32'd12, 32'd34, 5'd0, 1'b0, 1'b0, 32'd7);
        drive(1'b0, 32'hFC00_0000, 32'd102, 32'd202);
        tick();
        check_all("stall3", 1'b1, 5'd12, 32'd12, 32'd34, 5'd0, 1'b0, 1'b0, 32'd7);

        Stall = 1'b0;
        drive(1'b1, 32'h0022_1822, 32'd10, 32'd4);
        tick();
        check_all("sub_after_stall", 1'b1, 5'd2, 32'd10, 32'd4, 5'd3, 1'b1, 1'b0, 32'd8);

        Stall = 1'b1;
        Flush = 1'b1;
        tick();
        check_all("flush", 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'd8);

        Stall = 1'b0;
        Flush = 1'b0;
        drive(1'b1, 32'hFC00_0000, 32'd77, 32'd88);
        tick();
        check_all("illegal", 1'b1, 5'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 32'd9);

        drive(1'b0, 32'h0022_1820, 32'd5, 32'd7);
        tick();
        check_all("bubble", 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'd9);

        @(negedge Clk);
        force dut.r_issue_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_issue_count;
        #1;
        check("preset_count", IssueCount, 32'hFFFF_FFFF);
        drive(1'b1, 32'h0022_1820, 32'd5, 32'd7);
        tick();
        check("wrap_count", IssueCount, 32'd0);
        check("wrap_ctrl", {27'b0, ALUControl}, 32'd1);

        Reset = 1'b0;
        tick();
        check_all("midreset", 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
